button_command_conditioner: RTL and testbench
=============================================

BUTTON_COMMAND_CONDITIONER -- requirements
Module: button_command_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, consecutive stable cycles required to accept a level change (legal 1..65535).
REQ-002 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port btn_raw  input  4  raw asynchronous buttons: bit0 up, bit1 down, bit2 load, bit3 clear.
REQ-005 SHALL have port switches  input  4  raw asynchronous load value.
REQ-006 SHALL have port debounced  output  4  registered debounced button levels.
REQ-007 SHALL have port cmd_valid  output  1  command pending to downstream counter.
REQ-008 SHALL have port cmd_op  output  2  command code: 00 up, 01 down, 10 load, 11 clear.
REQ-009 SHALL have port cmd_value  output  4  load value; 0 for non-load ops.
REQ-010 SHALL have port cmd_ack  input  1  downstream accepts pending command.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse when a press is discarded.

Function
REQ-012 SHALL pass each btn_raw and switches bit through a 2-flop synchronizer before any other use.
REQ-013 SHALL keep per-button 16-bit counter: cleared when synced level equals debounced level; incremented otherwise.
REQ-014 SHALL update debounced[i] to the synced level and clear the counter on the edge where mismatch has been seen DEBOUNCE_CYCLES consecutive edges.
REQ-015 SHALL therefore raise/lower debounced[i] exactly DEBOUNCE_CYCLES+2 edges after btn_raw[i] changes and holds; any glitch shorter than DEBOUNCE_CYCLES synced cycles SHALL produce no change.
REQ-016 SHALL generate an internal one-cycle press for each debounced 0->1 transition; 1->0 transitions SHALL produce nothing.
REQ-017 SHALL, when cmd_valid is 0 (or is being acked this edge) and any press is present, load a command on that edge: cmd_valid=1, cmd_op from highest-priority press (clear > load > up > down).
REQ-018 SHALL set cmd_value to synced switches at issue for load, else 0; cmd_op/cmd_value SHALL stay constant while cmd_valid=1.
REQ-019 SHALL clear cmd_valid on the edge where cmd_valid=1 and cmd_ack=1 unless REQ-017 reloads on the same edge.
REQ-020 SHALL ignore cmd_ack while cmd_valid=0.
REQ-021 SHALL discard presses arriving while a command is pending and not acked, and losing presses of a simultaneous group; SHALL pulse overrun high for exactly one cycle on the edge of the discarded press.
REQ-022 SHALL NOT queue more than one command; no buffering beyond the single command register.
REQ-023 SHALL treat simultaneous up+down presses as up only, with overrun pulsed.

Reset
REQ-024 SHALL, on reset assertion, immediately clear synchronizers, debounce counters, debounced, cmd_valid, cmd_op, cmd_value, overrun to 0, independent of clock.
REQ-025 SHALL, when a button is held through reset release, assert debounced after DEBOUNCE_CYCLES+2 edges and issue one command.
REQ-026 SHALL drop any pending command on reset mid-handshake; no command reissued after release.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 Bench SHALL: btn_raw[0] high and held from edge 0, cmd_ack=0 -> debounced[0]=1 after edge 6, cmd_valid=1 cmd_op=00 cmd_value=0 from edge 6.
REQ-028 Bench SHALL: btn_raw[1] pulsed high for 3 cycles -> debounced stays 0000, cmd_valid never asserts.
REQ-029 Bench SHALL: switches=1010, btn_raw[2] and btn_raw[0] rise same cycle -> cmd_op=10, cmd_value=1010, overrun one-cycle pulse on issue edge.
REQ-030 Bench SHALL: command pending, cmd_ack=0, second button pressed -> overrun pulse, cmd_op unchanged; then cmd_ack one cycle -> cmd_valid=0 next cycle.
REQ-031 Bench SHALL: press matures on same edge cmd_ack=1 -> cmd_valid stays 1 with new cmd_op, no overrun.
REQ-032 Bench SHALL: reset asserted mid-clock while cmd_valid=1 -> all outputs 0 immediately; btn_raw[3] held -> cmd_op=11 issued 6 edges after release.

Source files
------------

// File: rtl/button_command_conditioner.sv
// button_command_conditioner: synchronizes and debounces four buttons, turns presses into
// a single-entry prioritized command register with overrun signalling.
module button_command_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] btn_raw,
  input  logic [3:0] switches,
  output logic [3:0] debounced,
  output logic       cmd_valid,
  output logic [1:0] cmd_op,
  output logic [3:0] cmd_value,
  input  logic       cmd_ack,
  output logic       overrun
);
  logic [3:0] btn_s1, btn_s2, sw_s1, sw_s2;
  logic [3:0] deb_next, press;
  logic       issue, multi;
  logic [1:0] op_next;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
      sw_s1  <= switches;
      sw_s2  <= sw_s1;
    end
  end
  for (genvar i = 0; i < 4; i++) begin : g_deb
    logic [15:0] cnt;
    logic        mature;
    // mature on the edge that completes DEBOUNCE_CYCLES consecutive mismatches
    assign mature      = (btn_s2[i] != debounced[i]) && ({1'b0, cnt} + 17'd1 == 17'(DEBOUNCE_CYCLES));
    assign deb_next[i] = mature ? btn_s2[i] : debounced[i];
    always_ff @(posedge clock or posedge reset) begin
      if (reset) cnt <= '0;
      else       cnt <= (btn_s2[i] == debounced[i] || mature) ? '0 : cnt + 16'd1;
    end
  end
  assign press   = deb_next & ~debounced;
  assign issue   = (|press) & (~cmd_valid | cmd_ack);
  assign multi   = (press & (press - 4'd1)) != 4'd0;
  assign op_next = press[3] ? 2'b11 : press[2] ? 2'b10 : press[0] ? 2'b00 : 2'b01;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      debounced <= '0;
      cmd_valid <= 1'b0;
      cmd_op    <= '0;
      cmd_value <= '0;
      overrun   <= 1'b0;
    end else begin
      debounced <= deb_next;
      overrun   <= (|press) & (~issue | multi);
      if (issue) begin
        cmd_valid <= 1'b1;
        cmd_op    <= op_next;
        cmd_value <= (op_next == 2'b10) ? sw_s2 : 4'd0;
      end else if (cmd_ack) begin
        cmd_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_button_command_conditioner.sv
// tb_button_command_conditioner: directed literal checks plus randomized run against a
// window-based behavioural model of debounce and the single-entry command register.
module tb_button_command_conditioner;
  localparam int D = 4;
  logic       clock, reset, cmd_ack, cmd_valid, overrun;
  logic [3:0] btn_raw, switches, debounced, cmd_value;
  logic [1:0] cmd_op;
  int checks = 0, errors = 0;

  button_command_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clock(clock), .reset(reset), .btn_raw(btn_raw), .switches(switches),
    .debounced(debounced), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_value(cmd_value), .cmd_ack(cmd_ack), .overrun(overrun)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  // model state: raw sample history (mh[k] = sample taken k+1 edges ago), switch history
  logic [3:0] mh [0:D];
  logic [3:0] ms [0:1];
  logic [3:0] m_deb, m_val, nd, pr, n_val;
  logic       m_valid, m_ovr, n_valid, n_ovr;
  logic [1:0] m_op, n_op;
  int         miss [4];

  // a debounced bit flips once the synchronized view (raw two edges old) disagreed D edges running
  always_comb begin
    nd = m_deb;
    for (int i = 0; i < 4; i++) begin
      miss[i] = 0;
      for (int j = 1; j <= D; j++) if (mh[j][i] != m_deb[i]) miss[i]++;
      if (miss[i] == D) nd[i] = ~m_deb[i];
    end
    pr = nd & ~m_deb;
    n_valid = m_valid;
    n_op = m_op;
    n_val = m_val;
    n_ovr = 0;
    if (pr != 0) begin
      if (!m_valid || cmd_ack) begin
        n_valid = 1;
        if (pr[3]) n_op = 2'd3;
        else if (pr[2]) n_op = 2'd2;
        else if (pr[0]) n_op = 2'd0;
        else n_op = 2'd1;
        n_val = (n_op == 2'd2) ? ms[1] : 4'd0;
        n_ovr = $countones(pr) > 1;
      end else n_ovr = 1;
    end else if (m_valid && cmd_ack) n_valid = 0;
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= D; k++) mh[k] <= '0;
      ms[0] <= '0; ms[1] <= '0;
      m_deb <= '0; m_valid <= 0; m_op <= '0; m_val <= '0; m_ovr <= 0;
    end else begin
      for (int k = 1; k <= D; k++) mh[k] <= mh[k-1];
      mh[0] <= btn_raw;
      ms[1] <= ms[0]; ms[0] <= switches;
      m_deb <= nd; m_valid <= n_valid; m_op <= n_op; m_val <= n_val; m_ovr <= n_ovr;
    end
  end

  always @(negedge clock) begin
    checks++;
    if ({debounced, cmd_valid, cmd_op, cmd_value, overrun} !== {m_deb, m_valid, m_op, m_val, m_ovr}) begin
      errors++;
      $display("FAIL model t=%0t deb/valid/op/value/ovr got %b/%b/%b/%b/%b exp %b/%b/%b/%b/%b", $time,
               debounced, cmd_valid, cmd_op, cmd_value, overrun, m_deb, m_valid, m_op, m_val, m_ovr);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic ack_once();
    cmd_ack = 1; cyc(1); cmd_ack = 0;
  endtask

  initial begin
    btn_raw = 0; switches = 0; cmd_ack = 0; reset = 1;
    cyc(3); reset = 0;
    chk("reset_valid", cmd_valid, 0);
    chk("reset_deb", debounced, 0);
    // single up press held
    btn_raw = 4'b0001; cyc(5);
    chk("up_deb_e5", debounced, 0);
    chk("up_valid_e5", cmd_valid, 0);
    cyc(1);
    chk("up_deb_e6", debounced, 1);
    chk("up_cmd_e6", {cmd_valid, cmd_op, cmd_value}, 7'b1_00_0000);
    ack_once();
    chk("up_acked", cmd_valid, 0);
    btn_raw = 0; cyc(8);
    // short glitch on down
    btn_raw = 4'b0010; cyc(3); btn_raw = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      chk("glitch_deb", debounced, 0);
      chk("glitch_valid", cmd_valid, 0);
    end
    // load and up together
    switches = 4'b1010; btn_raw = 4'b0101; cyc(6);
    chk("load_cmd", {cmd_valid, cmd_op, cmd_value}, 7'b1_10_1010);
    chk("load_ovr", overrun, 1);
    cyc(1);
    chk("load_ovr_end", overrun, 0);
    ack_once(); btn_raw = 0; cyc(8);
    // second press while pending
    btn_raw = 4'b0001; cyc(6);
    chk("pend_op", cmd_op, 0);
    btn_raw = 4'b0011; cyc(6);
    chk("pend_ovr", overrun, 1);
    chk("pend_cmd", {cmd_valid, cmd_op}, 3'b1_00);
    ack_once();
    chk("pend_cleared", cmd_valid, 0);
    btn_raw = 0; cyc(8);
    // press maturing on the ack edge reloads
    btn_raw = 4'b0001; cyc(6);
    btn_raw = 4'b1001; cyc(5);
    cmd_ack = 1; cyc(1); cmd_ack = 0;
    chk("reload_cmd", {cmd_valid, cmd_op}, 3'b1_11);
    chk("reload_ovr", overrun, 0);
    ack_once(); btn_raw = 0; cyc(8);
    // async reset mid-handshake, clear held through release
    btn_raw = 4'b0001; cyc(6);
    chk("pre_rst_valid", cmd_valid, 1);
    btn_raw = 4'b1000;
    @(posedge clock); #2 reset = 1; #1;
    chk("async_rst_outs", {debounced, cmd_valid, cmd_op, cmd_value, overrun}, 0);
    cyc(2); reset = 0; cyc(5);
    chk("post_rst_e5", cmd_valid, 0);
    cyc(1);
    chk("post_rst_cmd", {cmd_valid, cmd_op}, 3'b1_11);
    chk("post_rst_deb", debounced, 4'b1000);
    ack_once(); btn_raw = 0; cyc(8);
    // randomized run
    for (int n = 0; n < 4000; n++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 9) == 0) btn_raw[b] = ~btn_raw[b];
      if ($urandom_range(0, 3) == 0) switches = 4'($urandom);
      cmd_ack = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 499) == 0) begin
        @(posedge clock); #2 reset = 1;
        cyc(2); reset = 0;
      end else cyc(1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
